// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcodes, ALUOp encodings and the
// control bundle produced by the main decoder.
package legv8_pkg;

  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_NOR  = 11'b11101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ matches on the upper 8 bits; the low 3 opcode bits belong to the offset.
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       reg2loc;
    logic       uses_rn;
    logic       uses_r2;
    logic       legal;
  } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational main control decoder: 11-bit opcode to control bundle.
// Unrecognised opcodes decode to all-zero controls with legal=0.
module main_decoder
  import legv8_pkg::*;
(
  input  logic [10:0] i_opcode,
  output ctrl_t       o_ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the decode so no path can infer a latch.
    o_ctrl = '0;
    if (i_opcode[10:3] == OP_CBZ_HI) begin
      o_ctrl.aluop   = ALUOP_BR;
      o_ctrl.branch  = 1'b1;
      o_ctrl.reg2loc = 1'b1;
      o_ctrl.uses_r2 = 1'b1;
      o_ctrl.legal   = 1'b1;
    end else begin
      case (i_opcode)
        OP_AND, OP_ORR, OP_ADD, OP_SUB, OP_NOR: begin
          o_ctrl.aluop    = ALUOP_R;
          o_ctrl.regwrite = 1'b1;
          o_ctrl.uses_rn  = 1'b1;
          o_ctrl.uses_r2  = 1'b1;
          o_ctrl.legal    = 1'b1;
        end
        OP_LDUR: begin
          o_ctrl.aluop    = ALUOP_MEM;
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.memread  = 1'b1;
          o_ctrl.memtoreg = 1'b1;
          o_ctrl.regwrite = 1'b1;
          o_ctrl.uses_rn  = 1'b1;
          o_ctrl.legal    = 1'b1;
        end
        OP_STUR: begin
          o_ctrl.aluop    = ALUOP_MEM;
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.memwrite = 1'b1;
          o_ctrl.reg2loc  = 1'b1;
          o_ctrl.uses_rn  = 1'b1;
          o_ctrl.uses_r2  = 1'b1;
          o_ctrl.legal    = 1'b1;
        end
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/id_control_stage.sv
// ID-stage control: main decode, load-use hazard detection, ID/EX control
// register with bubble insertion, sticky illegal-opcode flag and stall counter.
module id_control_stage
  import legv8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [10:0]      id_opcode,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       id_rt,
  input  logic             flush,
  output logic             reg2loc,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_alusrc,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_regwrite,
  output logic             ex_branch,
  output logic [1:0]       ex_aluop,
  output logic [10:0]      ex_opcode,
  output logic [4:0]       ex_rd,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t      w_ctrl;
  logic [4:0] w_r2_addr;
  logic       w_hz;
  logic       w_stall;
  logic       w_load;

  logic             r_ex_valid;
  logic             r_ex_alusrc;
  logic             r_ex_memread;
  logic             r_ex_memwrite;
  logic             r_ex_memtoreg;
  logic             r_ex_regwrite;
  logic             r_ex_branch;
  logic [1:0]       r_ex_aluop;
  logic [10:0]      r_ex_opcode;
  logic [4:0]       r_ex_rd;
  logic             r_illegal;
  logic [CNT_W-1:0] r_stall_count;

  main_decoder u_main_decoder (
    .i_opcode (id_opcode),
    .o_ctrl   (w_ctrl)
  );

  assign w_r2_addr = w_ctrl.reg2loc ? id_rt : id_rm;

  // Only a real load writing a real register can create a load-use hazard.
  assign w_hz = r_ex_valid && r_ex_memread && (r_ex_rd != XZR)
             && id_valid && w_ctrl.legal
             && ((w_ctrl.uses_rn && (r_ex_rd == id_rn))
              || (w_ctrl.uses_r2 && (r_ex_rd == w_r2_addr)));

  assign w_stall = w_hz && !flush;
  assign w_load  = id_valid && w_ctrl.legal && !flush && !w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_aluop    <= 2'b00;
      r_ex_opcode   <= '0;
      r_ex_rd       <= '0;
    end else if (w_load) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_ex_valid    <= 1'b1;
      r_ex_alusrc   <= w_ctrl.alusrc;
      r_ex_memread  <= w_ctrl.memread;
      r_ex_memwrite <= w_ctrl.memwrite;
      r_ex_memtoreg <= w_ctrl.memtoreg;
      r_ex_regwrite <= w_ctrl.regwrite;
      r_ex_branch   <= w_ctrl.branch;
      r_ex_aluop    <= w_ctrl.aluop;
      r_ex_opcode   <= id_opcode;
      r_ex_rd       <= id_rt;
    end else begin
      r_ex_valid    <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_aluop    <= 2'b00;
      r_ex_opcode   <= '0;
      r_ex_rd       <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (id_valid && !w_ctrl.legal && !flush && !w_stall) begin
        r_illegal <= 1'b1;
      end
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign reg2loc     = w_ctrl.reg2loc;
  assign stall       = w_stall;
  assign ex_valid    = r_ex_valid;
  assign ex_alusrc   = r_ex_alusrc;
  assign ex_memread  = r_ex_memread;
  assign ex_memwrite = r_ex_memwrite;
  assign ex_memtoreg = r_ex_memtoreg;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_branch   = r_ex_branch;
  assign ex_aluop    = r_ex_aluop;
  assign ex_opcode   = r_ex_opcode;
  assign ex_rd       = r_ex_rd;
  assign illegal_op  = r_illegal;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_control_stage.sv
// Bench for id_control_stage: directed scenarios followed by random traffic,
// all compared against an instruction-level reference model.
module tb_id_control_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid = 1'b0;
  logic [10:0] id_opcode = '0;
  logic [4:0]  id_rn = '0, id_rm = '0, id_rt = '0;
  logic        flush = 1'b0;

  logic        a_reg2loc, a_stall, a_valid, a_alusrc, a_memread, a_memwrite;
  logic        a_memtoreg, a_regwrite, a_branch, a_illegal;
  logic [1:0]  a_aluop;
  logic [10:0] a_opcode;
  logic [4:0]  a_rd;
  logic [15:0] a_cnt;

  logic        b_reg2loc, b_stall, b_valid, b_alusrc, b_memread, b_memwrite;
  logic        b_memtoreg, b_regwrite, b_branch, b_illegal;
  logic [1:0]  b_aluop;
  logic [10:0] b_opcode;
  logic [4:0]  b_rd;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  id_control_stage #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .flush(flush),
    .reg2loc(a_reg2loc), .stall(a_stall), .ex_valid(a_valid), .ex_alusrc(a_alusrc),
    .ex_memread(a_memread), .ex_memwrite(a_memwrite), .ex_memtoreg(a_memtoreg),
    .ex_regwrite(a_regwrite), .ex_branch(a_branch), .ex_aluop(a_aluop),
    .ex_opcode(a_opcode), .ex_rd(a_rd), .illegal_op(a_illegal), .stall_count(a_cnt)
  );

  id_control_stage #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt), .flush(flush),
    .reg2loc(b_reg2loc), .stall(b_stall), .ex_valid(b_valid), .ex_alusrc(b_alusrc),
    .ex_memread(b_memread), .ex_memwrite(b_memwrite), .ex_memtoreg(b_memtoreg),
    .ex_regwrite(b_regwrite), .ex_branch(b_branch), .ex_aluop(b_aluop),
    .ex_opcode(b_opcode), .ex_rd(b_rd), .illegal_op(b_illegal), .stall_count(b_cnt)
  );

  typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_ILL} kind_t;

  // Expected EX-side state: {valid, alusrc, memread, memwrite, memtoreg, regwrite, branch, aluop}
  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
  } exp_ctrl_t;

  exp_ctrl_t   m_ctrl;
  logic [10:0] m_opcode;
  logic [4:0]  m_rd;
  int          m_cnt;
  logic        m_ill;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] r_ops [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic kind_t classify(input logic [10:0] op);
    if (op == 11'b10001010000 || op == 11'b10101010000 || op == 11'b10001011000 ||
        op == 11'b11001011000 || op == 11'b11101010000) return K_R;
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if ((op >> 3) == 11'(8'b10110100)) return K_CBZ;
    return K_ILL;
  endfunction

  function automatic exp_ctrl_t ctrl_of(input kind_t k);
    exp_ctrl_t c;
    case (k)
      K_R:     c = '{valid:1, alusrc:0, memread:0, memwrite:0, memtoreg:0, regwrite:1, branch:0, aluop:2'b10};
      K_LD:    c = '{valid:1, alusrc:1, memread:1, memwrite:0, memtoreg:1, regwrite:1, branch:0, aluop:2'b00};
      K_ST:    c = '{valid:1, alusrc:1, memread:0, memwrite:1, memtoreg:0, regwrite:0, branch:0, aluop:2'b00};
      K_CBZ:   c = '{valid:1, alusrc:0, memread:0, memwrite:0, memtoreg:0, regwrite:0, branch:1, aluop:2'b01};
      default: c = '0;
    endcase
    return c;
  endfunction

  // Reads the instruction actually performs, as a list of architectural source registers.
  function automatic logic hazard(input kind_t k, input logic v,
                                  input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt);
    logic [4:0] srcs [$];
    if (!(m_ctrl.valid && m_ctrl.memread) || m_rd == 5'd31 || !v || k == K_ILL) return 1'b0;
    case (k)
      K_R:     srcs = '{rn, rm};
      K_LD:    srcs = '{rn};
      K_ST:    srcs = '{rn, rt};
      default: srcs = '{rt};
    endcase
    foreach (srcs[i]) if (srcs[i] == m_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".ex_valid"},    {31'd0, a_valid},    {31'd0, m_ctrl.valid});
    check({tag, ".ex_ctrl"},     {25'd0, a_alusrc, a_memread, a_memwrite, a_memtoreg, a_regwrite, a_branch, a_aluop},
                                 {25'd0, m_ctrl.alusrc, m_ctrl.memread, m_ctrl.memwrite, m_ctrl.memtoreg,
                                  m_ctrl.regwrite, m_ctrl.branch, m_ctrl.aluop});
    check({tag, ".ex_opcode"},   {21'd0, a_opcode},   {21'd0, m_opcode});
    check({tag, ".ex_rd"},       {27'd0, a_rd},       {27'd0, m_rd});
    check({tag, ".illegal_op"},  {31'd0, a_illegal},  {31'd0, m_ill});
    check({tag, ".stall_count"}, {16'd0, a_cnt},      32'(sat(m_cnt, 65535)));
    check({tag, ".b_match"},     {b_valid, b_alusrc, b_memread, b_memwrite, b_memtoreg, b_regwrite, b_branch,
                                  b_aluop, b_opcode, b_rd, b_illegal},
                                 {a_valid, a_alusrc, a_memread, a_memwrite, a_memtoreg, a_regwrite, a_branch,
                                  a_aluop, a_opcode, a_rd, a_illegal});
    check({tag, ".b_stall_count"}, {30'd0, b_cnt}, 32'(sat(m_cnt, 3)));
  endtask

  task automatic step(input string tag, input logic v, input logic [10:0] op,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt,
                      input logic fl, output logic stalled);
    kind_t k;
    logic  hz, st;
    id_valid = v; id_opcode = op; id_rn = rn; id_rm = rm; id_rt = rt; flush = fl;
    #1;
    k  = classify(op);
    hz = hazard(k, v, rn, rm, rt);
    st = hz && !fl;
    check({tag, ".stall"},   {30'd0, b_stall, a_stall}, {30'd0, st, st});
    check({tag, ".reg2loc"}, {30'd0, b_reg2loc, a_reg2loc},
          {30'd0, {2{(k == K_ST) || (k == K_CBZ)}}});
    @(posedge clk);
    if (fl || st || !v || k == K_ILL) begin
      m_ctrl = '0; m_opcode = '0; m_rd = '0;
    end else begin
      m_ctrl = ctrl_of(k); m_opcode = op; m_rd = rt;
    end
    if (st) m_cnt++;
    if (v && k == K_ILL && !fl && !st) m_ill = 1'b1;
    #1;
    check_regs(tag);
    stalled = st;
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_opcode = '0; m_rd = '0; m_cnt = 0; m_ill = 1'b0;
  endtask

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BAD  = 11'b11111111111;

  initial begin
    logic        s;
    logic        held;
    logic        v, fl;
    logic [10:0] op;
    logic [4:0]  rn, rm, rt;
    int          sel;

    r_ops = '{11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000, 11'b11101010000};
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_regs("reset");
    #18 rst_n = 1'b1;

    step("add", 1, ADD, 5'd1, 5'd2, 5'd3, 0, s);
    check("add.aluop", {30'd0, a_aluop}, 32'h2);
    check("add.opcode", {21'd0, a_opcode}, {21'd0, ADD});

    step("ldur5", 1, LDUR, 5'd0, 5'd0, 5'd5, 0, s);
    step("add_dep", 1, ADD, 5'd5, 5'd2, 5'd6, 0, s);
    check("loaduse.stall", {31'd0, s}, 32'd1);
    check("loaduse.bubble", {31'd0, a_valid}, 32'd0);
    step("add_held", 1, ADD, 5'd5, 5'd2, 5'd6, 0, s);
    check("loaduse.proceed", {31'd0, s | ~a_valid}, 32'd0);
    check("loaduse.count", {16'd0, a_cnt}, 32'd1);

    step("ldur5b", 1, LDUR, 5'd0, 5'd0, 5'd5, 0, s);
    step("stur_rt", 1, STUR, 5'd1, 5'd9, 5'd5, 0, s);
    check("stur.stall", {31'd0, s}, 32'd1);
    step("stur_held", 1, STUR, 5'd1, 5'd9, 5'd5, 0, s);

    step("ldur31", 1, LDUR, 5'd0, 5'd0, 5'd31, 0, s);
    step("stur_xzr", 1, STUR, 5'd31, 5'd9, 5'd31, 0, s);
    check("xzr.nostall", {31'd0, s}, 32'd0);

    step("ldur_ll", 1, LDUR, 5'd0, 5'd0, 5'd7, 0, s);
    step("ldur_dep", 1, LDUR, 5'd7, 5'd0, 5'd8, 0, s);
    step("ldur_held", 1, LDUR, 5'd7, 5'd0, 5'd8, 0, s);
    step("cbz_dep", 1, CBZ, 5'd0, 5'd0, 5'd8, 0, s);
    step("cbz_held", 1, CBZ, 5'd0, 5'd0, 5'd8, 0, s);

    step("ldur_fl", 1, LDUR, 5'd0, 5'd0, 5'd4, 0, s);
    step("hz_flush", 1, ADD, 5'd4, 5'd4, 5'd1, 1, s);
    check("flush.nostall", {31'd0, s}, 32'd0);
    check("flush.bubble", {31'd0, a_valid}, 32'd0);

    step("illegal", 1, BAD, 5'd1, 5'd2, 5'd3, 0, s);
    check("illegal.set", {31'd0, a_illegal}, 32'd1);
    step("after_ill", 1, ADD, 5'd1, 5'd2, 5'd3, 0, s);
    check("illegal.sticky", {31'd0, a_illegal}, 32'd1);

    #3 rst_n = 1'b0;
    model_reset();
    #1 check_regs("async_reset");
    #9 rst_n = 1'b1;
    #3;

    for (int i = 0; i < 5; i++) begin
      step("sat_ld", 1, LDUR, 5'd0, 5'd0, 5'd10, 0, s);
      step("sat_use", 1, ADD, 5'd3, 5'd10, 5'd11, 0, s);
      step("sat_go", 1, ADD, 5'd3, 5'd10, 5'd11, 0, s);
    end
    check("sat.b", {30'd0, b_cnt}, 32'd3);
    check("sat.a", {16'd0, a_cnt}, 32'd5);

    held = 1'b0;
    v = 1'b0; op = '0; rn = '0; rm = '0; rt = '0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        sel = $urandom_range(0, 9);
        if (sel < 5)       op = r_ops[sel];
        else if (sel < 7)  op = LDUR;
        else if (sel == 7) op = STUR;
        else if (sel == 8) op = {8'b10110100, 3'($urandom)};
        else               op = 11'($urandom);
        rn = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        rm = 5'($urandom_range(0, 7));
        rt = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        v  = ($urandom_range(0, 9) != 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      step("rand", v, op, rn, rm, rt, fl, held);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
